// File: rtl/sle_bist_if.sv
// Connection bundle between the SLE BIST controller and its environment.
// Handshake: start is a level that is sampled only while the controller is
// idle. An accepted start raises busy in the next cycle. busy stays high
// through the single-cycle done pulse. pass, err_cnt and fail_idx are valid
// from the done cycle until the next accepted start. There is no backpressure.
// The sle_* signals are the stimulus for the element under test, and sle_q
// is its response.
interface sle_bist_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [7:0] fail_idx;
    logic       sle_d;
    logic       sle_en;
    logic       sle_sln;
    logic       sle_sd;
    logic       sle_adn;
    logic       sle_aln;
    logic       sle_lat;
    logic       sle_q;

    // Controller side
    modport master (
        input  start, sle_q,
        output busy, done, pass, err_cnt, fail_idx,
               sle_d, sle_en, sle_sln, sle_sd, sle_adn, sle_aln, sle_lat
    );

    // Environment side: requester plus the element under test
    modport slave (
        output start, sle_q,
        input  busy, done, pass, err_cnt, fail_idx,
               sle_d, sle_en, sle_sln, sle_sd, sle_adn, sle_aln, sle_lat
    );
endinterface

// File: rtl/sle_bist.sv
// Built-in self-test controller for one SLE flop/latch primitive.
// An LFSR supplies the stimulus. A one-bit reference model tracks the
// expected Q, and every check compares the sampled Q against that model.
// One run has an init check, then N_VECT flop-mode vectors, then N_VECT
// latch-mode vectors. Each vector uses one APPLY cycle and one CHECK cycle.
module sle_bist #(
    parameter int unsigned N_VECT = 15,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    sle_bist_if.master bus,
    output logic [2:0] dbg_state
);

    // A zero seed would lock the LFSR, so it is replaced by 8'h01.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [8:0] FLOP_VECS = 9'(N_VECT);
    localparam logic [8:0] LAST_VEC  = 9'(2 * N_VECT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        INIT_CHK = 3'd2,
        APPLY    = 3'd3,
        CHECK    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] lfsr;
    logic       exp_q;
    logic [8:0] vec_cnt;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [7:0] err_cnt_r;
    logic [7:0] fail_idx_r;
    logic       sle_d_r;
    logic       sle_en_r;
    logic       sle_sln_r;
    logic       sle_sd_r;
    logic       sle_adn_r;
    logic       sle_aln_r;
    logic       sle_lat_r;

    logic [7:0] lfsr_next;
    logic [8:0] vec_next;
    logic       is_check;
    logic       mismatch;
    logic       enter_apply;
    logic [7:0] err_next;
    logic [7:0] idx_cur;

    // Next LFSR value, check/mismatch decode and the saturating error count
    always_comb begin
        // The x^8+x^6+x^5+x^4+1 taps map to bits 0, 2, 3 and 4 when the
        // register shifts toward bit 0.
        lfsr_next   = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[4], lfsr[7:1]};
        vec_next    = vec_cnt + 9'd1;
        is_check    = (state == INIT_CHK) || (state == CHECK);
        mismatch    = is_check && (bus.sle_q != exp_q);
        enter_apply = (state == INIT_CHK) || ((state == CHECK) && (vec_cnt != LAST_VEC));
        err_next    = err_cnt_r;
        if (mismatch && (err_cnt_r != 8'hFF)) begin
            err_next = err_cnt_r + 8'd1;
        end
        // Indices above 254 cannot be held in 8 bits, and 8'hFF already
        // means "no failure". They are therefore clamped to 8'hFE.
        idx_cur = (vec_cnt > 9'd254) ? 8'hFE : vec_cnt[7:0];
    end

    // Sequencer FSM with registered status, stimulus and reference model
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            exp_q      <= 1'b0;
            vec_cnt    <= 9'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= 8'd0;
            fail_idx_r <= 8'hFF;
            sle_d_r    <= 1'b0;
            sle_en_r   <= 1'b0;
            sle_sln_r  <= 1'b0;
            sle_sd_r   <= 1'b0;
            sle_adn_r  <= 1'b0;
            sle_aln_r  <= 1'b1;
            sle_lat_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        lfsr       <= SEED_EFF;
                        err_cnt_r  <= 8'd0;
                        pass_r     <= 1'b0;
                        vec_cnt    <= 9'd0;
                        fail_idx_r <= 8'hFF;
                        busy_r     <= 1'b1;
                        // Async-load Q to ~ADn = 0 during INIT.
                        // Enable is dropped so the element stays quiet
                        // until vector 1.
                        sle_aln_r  <= 1'b0;
                        sle_adn_r  <= 1'b1;
                        sle_lat_r  <= 1'b0;
                        sle_en_r   <= 1'b0;
                        exp_q      <= 1'b0;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    sle_aln_r <= 1'b1;
                    state     <= INIT_CHK;
                end
                INIT_CHK: begin
                    state <= APPLY;
                end
                APPLY: begin
                    // The element captures on this edge, so the model
                    // captures on it too.
                    if (sle_en_r) begin
                        exp_q <= sle_sln_r ? sle_d_r : sle_sd_r;
                    end
                    state <= CHECK;
                end
                CHECK: begin
                    if (vec_cnt == LAST_VEC) begin
                        done_r <= 1'b1;
                        pass_r <= (err_next == 8'd0);
                        state  <= DONE;
                    end else begin
                        state <= APPLY;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (is_check) begin
                err_cnt_r <= err_next;
                if (mismatch && (fail_idx_r == 8'hFF)) begin
                    fail_idx_r <= idx_cur;
                end
            end

            if (enter_apply) begin
                lfsr      <= lfsr_next;
                vec_cnt   <= vec_next;
                sle_d_r   <= lfsr_next[0];
                sle_en_r  <= lfsr_next[1];
                sle_sln_r <= lfsr_next[2];
                sle_sd_r  <= lfsr_next[3];
                sle_adn_r <= lfsr_next[4];
                sle_lat_r <= (vec_next > FLOP_VECS);
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.err_cnt  = err_cnt_r;
    assign bus.fail_idx = fail_idx_r;
    assign bus.sle_d    = sle_d_r;
    assign bus.sle_en   = sle_en_r;
    assign bus.sle_sln  = sle_sln_r;
    assign bus.sle_sd   = sle_sd_r;
    assign bus.sle_adn  = sle_adn_r;
    assign bus.sle_aln  = sle_aln_r;
    assign bus.sle_lat  = sle_lat_r;
    assign dbg_state    = state;

endmodule
